// File: rtl/pc_branch_unit_if.sv
// Fetch-stage bus between decode/control logic and the PC/branch unit.
// Carries control inputs, the LUT write port and the PC/status outputs.
interface pc_branch_unit_if #(
   parameter int D = 12,
   parameter int N = 8,
   parameter int A = $clog2(N),
   parameter int C = 8
);
   logic          Start;
   logic          stall;
   logic          halt;
   logic          branch_en;
   logic          taken;
   logic [A-1:0]  addr_lut;
   logic          wr_en;
   logic [A-1:0]  wr_addr;
   logic [D-1:0]  wr_target;
   logic          wr_abs;
   logic [D-1:0]  PC;
   logic          done;
   logic [C-1:0]  taken_cnt;
   logic [D-1:0]  target;

   // Decode/control side drives the controls and observes the PC state.
   modport master (
      output Start, stall, halt, branch_en, taken, addr_lut,
             wr_en, wr_addr, wr_target, wr_abs,
      input  PC, done, taken_cnt, target
   );

   // The PC/branch unit itself.
   modport slave (
      input  Start, stall, halt, branch_en, taken, addr_lut,
             wr_en, wr_addr, wr_target, wr_abs,
      output PC, done, taken_cnt, target
   );
endinterface

// File: rtl/pc_branch_unit.sv
// Program counter with a runtime-writable branch-target LUT, stall/halt
// handling and a saturating count of taken branches.
module pc_branch_unit #(
   parameter int D = 12,
   parameter int N = 8,
   parameter int A = $clog2(N),
   parameter int C = 8
) (
   input logic             Clk,
   input logic             Reset,
   pc_branch_unit_if.slave bus
);

   // The LUT is sized to the full index space so every index can be read
   // safely; slots at or above N are never written and never selected.
   localparam int DEPTH = 2 ** A;

   logic [D-1:0] lut_target [DEPTH];
   logic         lut_abs    [DEPTH];
   logic [D-1:0] pc_q;
   logic         done_q;
   logic [C-1:0] cnt_q;
   logic [D-1:0] target_val;
   logic         rd_ok;
   logic         wr_ok;

   // Indices beyond the populated entries only exist when N is not a power of two.
   if (DEPTH == N) begin : g_full
      assign rd_ok = 1'b1;
      assign wr_ok = 1'b1;
   end else begin : g_part
      assign rd_ok = ({{(32-A){1'b0}}, bus.addr_lut} < 32'(N));
      assign wr_ok = ({{(32-A){1'b0}}, bus.wr_addr}  < 32'(N));
   end

   // Next-PC for a taken branch; an unpopulated index behaves as "hold".
   always_comb begin
      target_val = pc_q;
      if (rd_ok) begin
         if (lut_abs[bus.addr_lut])
            target_val = lut_target[bus.addr_lut];
         else
            target_val = pc_q + lut_target[bus.addr_lut];
      end
   end

   // LUT write port; reset leaves every entry as relative 0, i.e. hold PC.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            lut_target[i] <= '0;
            lut_abs[i]    <= 1'b0;
         end
      end else if (bus.wr_en && wr_ok) begin
         lut_target[bus.wr_addr] <= bus.wr_target;
         lut_abs[bus.wr_addr]    <= bus.wr_abs;
      end
   end

   // PC sequencing: restart, retired halt, stall, halt, taken branch, increment.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_q   <= '0;
         done_q <= 1'b0;
         cnt_q  <= '0;
      end else if (bus.Start) begin
         pc_q   <= '0;
         done_q <= 1'b0;
      end else if (done_q || bus.stall) begin
         pc_q <= pc_q;
      end else if (bus.halt) begin
         done_q <= 1'b1;
      end else if (bus.branch_en && bus.taken) begin
         pc_q <= target_val;
         if (cnt_q != '1)
            cnt_q <= cnt_q + C'(1);
      end else begin
         pc_q <= pc_q + D'(1);
      end
   end

   assign bus.PC        = pc_q;
   assign bus.done      = done_q;
   assign bus.taken_cnt = cnt_q;
   assign bus.target    = target_val;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: a default instance (N=8, C=8) and a
// small instance (N=6, C=2) for counter saturation and unpopulated indices.
module tb_pc_branch_unit;

   logic Clk;
   logic Reset;
   logic Reset_s;
   int   num_compared;
   int   num_mismatched;

   pc_branch_unit_if #(.D(12), .N(8), .C(8)) bus ();
   pc_branch_unit_if #(.D(12), .N(6), .C(2)) bus_s ();

   pc_branch_unit #(.D(12), .N(8), .C(8)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   pc_branch_unit #(.D(12), .N(6), .C(2)) dut_s (
      .Clk   (Clk),
      .Reset (Reset_s),
      .bus   (bus_s)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Drive every control of the default instance to idle.
   task automatic idle();
      bus.Start = 0; bus.stall = 0; bus.halt = 0; bus.branch_en = 0;
      bus.taken = 0; bus.addr_lut = '0; bus.wr_en = 0; bus.wr_addr = '0;
      bus.wr_target = '0; bus.wr_abs = 0;
   endtask

   // Drive every control of the small instance to idle.
   task automatic idle_s();
      bus_s.Start = 0; bus_s.stall = 0; bus_s.halt = 0; bus_s.branch_en = 0;
      bus_s.taken = 0; bus_s.addr_lut = '0; bus_s.wr_en = 0; bus_s.wr_addr = '0;
      bus_s.wr_target = '0; bus_s.wr_abs = 0;
   endtask

   // Reset state, then five plain increments.
   task automatic test_reset();
      idle(); idle_s();
      Reset = 1; Reset_s = 1;
      step(); step();
      Reset = 0; Reset_s = 0;
      num_compared++;
      if (bus.PC !== 12'd0) begin num_mismatched++; $display("FAIL reset_pc: got %0h want %0h", bus.PC, 12'd0); end
      num_compared++;
      if (bus.done !== 1'b0) begin num_mismatched++; $display("FAIL reset_done: got %0b want 0", bus.done); end
      num_compared++;
      if (bus.taken_cnt !== 8'd0) begin num_mismatched++; $display("FAIL reset_cnt: got %0d want 0", bus.taken_cnt); end
      num_compared++;
      if (bus.target !== 12'd0) begin num_mismatched++; $display("FAIL reset_target: got %0h want 0", bus.target); end
      for (int i = 1; i <= 5; i++) begin
         step();
         num_compared++;
         if (bus.PC !== 12'(i)) begin num_mismatched++; $display("FAIL inc_pc[%0d]: got %0h want %0h", i, bus.PC, 12'(i)); end
      end
   endtask

   // Relative entry with a negative offset, taken and not taken.
   task automatic test_relative();
      bus.wr_en = 1; bus.wr_addr = 3'd0; bus.wr_target = 12'hFFB; bus.wr_abs = 0;
      step();
      bus.wr_en = 0;
      step(); step();
      bus.branch_en = 1; bus.taken = 1; bus.addr_lut = 3'd0;
      #1;
      num_compared++;
      if (bus.target !== 12'd3) begin num_mismatched++; $display("FAIL rel_target: got %0h want 3", bus.target); end
      step();
      num_compared++;
      if (bus.PC !== 12'd3) begin num_mismatched++; $display("FAIL rel_taken_pc: got %0h want 3", bus.PC); end
      num_compared++;
      if (bus.taken_cnt !== 8'd1) begin num_mismatched++; $display("FAIL rel_taken_cnt: got %0d want 1", bus.taken_cnt); end
      bus.branch_en = 0; bus.taken = 0;
      for (int i = 0; i < 5; i++) step();
      bus.branch_en = 1; bus.taken = 0;
      step();
      num_compared++;
      if (bus.PC !== 12'd9) begin num_mismatched++; $display("FAIL not_taken_pc: got %0h want 9", bus.PC); end
      num_compared++;
      if (bus.taken_cnt !== 8'd1) begin num_mismatched++; $display("FAIL not_taken_cnt: got %0d want 1", bus.taken_cnt); end
      bus.branch_en = 0;
   endtask

   // Absolute jump then a relative -1 step, entered via Start.
   task automatic test_absolute();
      bus.wr_en = 1; bus.wr_addr = 3'd1; bus.wr_target = 12'd20; bus.wr_abs = 1;
      step();
      bus.wr_addr = 3'd2; bus.wr_target = 12'hFFF; bus.wr_abs = 0;
      step();
      bus.wr_en = 0; bus.Start = 1;
      step();
      bus.Start = 0;
      num_compared++;
      if (bus.PC !== 12'd0) begin num_mismatched++; $display("FAIL start_pc: got %0h want 0", bus.PC); end
      for (int i = 0; i < 7; i++) step();
      bus.branch_en = 1; bus.taken = 1; bus.addr_lut = 3'd1;
      step();
      num_compared++;
      if (bus.PC !== 12'd20) begin num_mismatched++; $display("FAIL abs_pc: got %0h want 20", bus.PC); end
      bus.addr_lut = 3'd2;
      step();
      num_compared++;
      if (bus.PC !== 12'd19) begin num_mismatched++; $display("FAIL rel_m1_pc: got %0h want 19", bus.PC); end
      num_compared++;
      if (bus.taken_cnt !== 8'd3) begin num_mismatched++; $display("FAIL abs_cnt: got %0d want 3", bus.taken_cnt); end
      bus.branch_en = 0; bus.taken = 0;
   endtask

   // Write and branch to the same entry on one edge use the old entry.
   task automatic test_same_cycle_write();
      bus.wr_en = 1; bus.wr_addr = 3'd3; bus.wr_target = 12'd100; bus.wr_abs = 1;
      bus.branch_en = 1; bus.taken = 1; bus.addr_lut = 3'd3;
      #1;
      num_compared++;
      if (bus.target !== 12'd19) begin num_mismatched++; $display("FAIL old_entry_target: got %0h want 19", bus.target); end
      step();
      bus.wr_en = 0;
      num_compared++;
      if (bus.PC !== 12'd19) begin num_mismatched++; $display("FAIL old_entry_pc: got %0h want 19", bus.PC); end
      num_compared++;
      if (bus.target !== 12'd100) begin num_mismatched++; $display("FAIL new_entry_target: got %0h want 100", bus.target); end
      step();
      num_compared++;
      if (bus.PC !== 12'd100) begin num_mismatched++; $display("FAIL new_entry_pc: got %0h want 100", bus.PC); end
      num_compared++;
      if (bus.taken_cnt !== 8'd5) begin num_mismatched++; $display("FAIL same_cycle_cnt: got %0d want 5", bus.taken_cnt); end
      bus.branch_en = 0; bus.taken = 0;
   endtask

   // PC wrap, stall, halt/done stickiness and restart keeping the LUT.
   task automatic test_wrap_stall_halt();
      bus.wr_en = 1; bus.wr_addr = 3'd4; bus.wr_target = 12'hFFF; bus.wr_abs = 1;
      step();
      bus.wr_en = 0; bus.branch_en = 1; bus.taken = 1; bus.addr_lut = 3'd4;
      step();
      bus.branch_en = 0; bus.taken = 0;
      num_compared++;
      if (bus.PC !== 12'hFFF) begin num_mismatched++; $display("FAIL to_fff_pc: got %0h want fff", bus.PC); end
      step();
      num_compared++;
      if (bus.PC !== 12'd0) begin num_mismatched++; $display("FAIL wrap_pc: got %0h want 0", bus.PC); end
      step();
      bus.stall = 1; bus.branch_en = 1; bus.taken = 1; bus.addr_lut = 3'd1;
      bus.wr_en = 1; bus.wr_addr = 3'd5; bus.wr_target = 12'd50; bus.wr_abs = 1;
      step();
      bus.stall = 0; bus.wr_en = 0;
      num_compared++;
      if (bus.PC !== 12'd1) begin num_mismatched++; $display("FAIL stall_pc: got %0h want 1", bus.PC); end
      num_compared++;
      if (bus.taken_cnt !== 8'd6) begin num_mismatched++; $display("FAIL stall_cnt: got %0d want 6", bus.taken_cnt); end
      bus.halt = 1;
      step();
      bus.halt = 0;
      num_compared++;
      if (bus.PC !== 12'd1) begin num_mismatched++; $display("FAIL halt_pc: got %0h want 1", bus.PC); end
      num_compared++;
      if (bus.done !== 1'b1) begin num_mismatched++; $display("FAIL halt_done: got %0b want 1", bus.done); end
      step();
      num_compared++;
      if (bus.PC !== 12'd1) begin num_mismatched++; $display("FAIL done_hold_pc: got %0h want 1", bus.PC); end
      num_compared++;
      if (bus.taken_cnt !== 8'd6) begin num_mismatched++; $display("FAIL done_hold_cnt: got %0d want 6", bus.taken_cnt); end
      num_compared++;
      if (bus.done !== 1'b1) begin num_mismatched++; $display("FAIL done_sticky: got %0b want 1", bus.done); end
      bus.branch_en = 0; bus.taken = 0; bus.Start = 1;
      step();
      bus.Start = 0;
      num_compared++;
      if (bus.PC !== 12'd0 || bus.done !== 1'b0) begin num_mismatched++; $display("FAIL restart: got pc=%0h done=%0b want pc=0 done=0", bus.PC, bus.done); end
      bus.branch_en = 1; bus.taken = 1; bus.addr_lut = 3'd5;
      step();
      num_compared++;
      if (bus.PC !== 12'd50) begin num_mismatched++; $display("FAIL retained_lut_pc: got %0h want 50", bus.PC); end
      num_compared++;
      if (bus.taken_cnt !== 8'd7) begin num_mismatched++; $display("FAIL restart_cnt: got %0d want 7", bus.taken_cnt); end
      bus.branch_en = 0; bus.taken = 0;
   endtask

   // Two-bit counter saturation, unpopulated index, reset mid-sequence.
   task automatic test_saturate();
      bus_s.wr_en = 1; bus_s.wr_addr = 3'd0; bus_s.wr_target = 12'd40; bus_s.wr_abs = 1;
      step();
      bus_s.wr_en = 0; bus_s.branch_en = 1; bus_s.taken = 1; bus_s.addr_lut = 3'd0;
      for (int i = 1; i <= 5; i++) begin
         step();
         num_compared++;
         if (bus_s.taken_cnt !== 2'((i > 3) ? 3 : i)) begin
            num_mismatched++;
            $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, bus_s.taken_cnt, (i > 3) ? 3 : i);
         end
      end
      num_compared++;
      if (bus_s.PC !== 12'd40) begin num_mismatched++; $display("FAIL sat_pc: got %0h want 40", bus_s.PC); end
      bus_s.addr_lut = 3'd7;
      #1;
      num_compared++;
      if (bus_s.target !== 12'd40) begin num_mismatched++; $display("FAIL oor_target: got %0h want 40", bus_s.target); end
      step();
      num_compared++;
      if (bus_s.PC !== 12'd40) begin num_mismatched++; $display("FAIL oor_pc: got %0h want 40", bus_s.PC); end
      Reset_s = 1; bus_s.addr_lut = 3'd0;
      bus_s.wr_en = 1; bus_s.wr_addr = 3'd1; bus_s.wr_target = 12'd33; bus_s.wr_abs = 1;
      step();
      Reset_s = 0; bus_s.wr_en = 0;
      num_compared++;
      if (bus_s.PC !== 12'd0 || bus_s.taken_cnt !== 2'd0) begin
         num_mismatched++;
         $display("FAIL mid_reset: got pc=%0h cnt=%0d want pc=0 cnt=0", bus_s.PC, bus_s.taken_cnt);
      end
      step();
      num_compared++;
      if (bus_s.PC !== 12'd0 || bus_s.taken_cnt !== 2'd1) begin
         num_mismatched++;
         $display("FAIL reset_entry0: got pc=%0h cnt=%0d want pc=0 cnt=1", bus_s.PC, bus_s.taken_cnt);
      end
      bus_s.addr_lut = 3'd1;
      step();
      num_compared++;
      if (bus_s.PC !== 12'd0) begin num_mismatched++; $display("FAIL reset_write_ignored: got %0h want 0", bus_s.PC); end
      idle_s();
   endtask

   initial begin
      num_compared   = 0;
      num_mismatched = 0;
      Reset   = 1;
      Reset_s = 1;
      idle();
      idle_s();
      #2;
      test_reset();
      test_relative();
      test_absolute();
      test_same_cycle_write();
      test_wrap_stall_halt();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
      $finish;
   end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Parametrised successor to the fixed 4-entry branch-target table: program counter register plus a runtime-writable branch-target LUT of N entries.
- Each entry holds a D-bit target and a mode bit, relative (signed offset added to PC) or absolute (jump address).
- Also provides stall, halt/done and a saturating taken-branch counter.
- Sits in the fetch stage; PC drives instruction ROM address, and decode supplies branch_en/taken/addr_lut.

Parameters:
D, 12, PC and target width; all PC arithmetic is modulo 2**D
N, 8, number of LUT entries (>=2)
A, $clog2(N), LUT index width
C, 8, width of taken-branch counter

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  synchronous restart: PC<=0, done<=0, counter kept
stall  input  1  hold PC this cycle
halt  input  1  decoded halt instruction at current PC
branch_en  input  1  current instruction is a branch
taken  input  1  branch condition true
addr_lut  input  A  LUT index for current branch
wr_en  input  1  LUT write strobe
wr_addr  input  A  LUT write index
wr_target  input  D  value written to entry
wr_abs  input  1  mode written: 1 absolute, 0 relative
PC  output  D  current program counter
done  output  1  high once halt has retired, sticky
taken_cnt  output  C  number of taken branches, saturating
target  output  D  combinational next-PC for a taken branch at addr_lut (debug/forwarding)

Behaviour:
- Reset (highest priority): PC=0, done=0, taken_cnt=0. All LUT entries become target=0, mode relative, i.e. hold PC, matching the old table's default.
- Start (next priority, Reset low): PC<=0, done<=0. LUT and taken_cnt unchanged.
- target = entry abs ? entry.target : (PC + entry.target) mod 2**D. Relative targets are two's-complement, e.g. 12'hFFB = -5, 12'hFFF = -1.
- Next-PC priority when not in reset/Start:
  - done=1: hold.
  - stall=1: hold; halt, branch and counter are ignored this cycle.
  - halt=1: hold; done<=1 on the same edge. Halt wins over a simultaneous branch.
  - branch_en & taken: PC<=target and taken_cnt increments, saturating at 2**C-1.
  - Otherwise (including branch_en with !taken): PC<=(PC+1) mod 2**D, so 12'hFFF wraps to 0.
- LUT write:
  - wr_en writes {wr_abs, wr_target} at wr_addr on the clock edge. Ignored during Reset; allowed during Start, stall and done.
  - Same-cycle write and branch to the same entry: the branch uses the OLD entry; the new value is visible from the next cycle.
  - wr_addr and addr_lut >= N (N not a power of 2): write dropped, read returns target=PC (hold).
- Latency: PC changes one cycle after its qualifying inputs; target is zero-latency combinational.
- done stays high until Reset or Start.
- No X propagation: every register has a defined reset value.

Test Plan:
- Reset then 5 cycles of no branch -> PC 0,1,2,3,4,5; done=0; taken_cnt=0.
- Write entry0 = relative 12'hFFB. At PC=8, branch_en=1, taken=1, addr_lut=0 -> PC=3, taken_cnt=1. Same with taken=0 -> PC=9, count unchanged.
- Write entry1 = absolute 20 and entry2 = relative 12'hFFF. From PC=7: branch via entry1 -> PC=20; then branch via entry2 -> PC=19 (20-1).
- Same-cycle write entry3 = absolute 100 with branch on entry3 (reset value relative 0) -> PC holds. Next branch on entry3 -> PC=100.
- PC=12'hFFF, no branch -> PC=0. Then stall=1 with taken branch -> PC held, taken_cnt unchanged. Then halt=1 together with a taken branch -> PC held, done=1 next cycle; further branches are ignored until Start, which gives PC=0, done=0 with LUT contents retained.
- With C=2: 5 taken branches -> taken_cnt 1,2,3,3,3. Assert Reset mid-sequence -> PC=0, taken_cnt=0, all entries hold.
